// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// FSM encoding, requester count and default widths.
package mem_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NUM_REQ       = 2;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_MAX_BURST = 4;

    // Width needed to hold a burst count of 0..max_burst (never below 1 bit).
    function automatic int burst_cnt_w(input int max_burst);
        int w;
        w = $clog2(max_burst + 1);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin choice: with both requesters valid, the one not
// served last wins; otherwise the single valid requester wins.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid,
    input  logic               last,
    output logic               any,
    output logic               pick
);

    // Pick the winner from the valids and the last-served pointer.
    always_comb begin
        any  = |valid;
        pick = 1'b0;
        if (valid == 2'b11) begin
            pick = ~last;
        end else if (valid[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates two requesters onto one memory with an asynchronous read port
// and a synchronous write port; supports bounded locked bursts.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,

    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int               CNT_W   = burst_cnt_w(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    arb_state_e        state_r, state_s;
    logic              gsel_r, gsel_s;
    logic              rr_last_r, rr_last_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;

    logic              any_s, pick_s;
    logic              sel_valid_s, sel_we_s, sel_lock_s, other_valid_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    logic              access_s, wr_s, rd0_s, rd1_s;

    rr_pick u_rr_pick (
        .valid ({req1_valid, req0_valid}),
        .last  (rr_last_r),
        .any   (any_s),
        .pick  (pick_s)
    );

    // Route the granted requester's request fields.
    always_comb begin
        if (gsel_r) begin
            sel_valid_s   = req1_valid;
            sel_we_s      = req1_we;
            sel_addr_s    = req1_addr;
            sel_wdata_s   = req1_wdata;
            sel_lock_s    = req1_lock;
            other_valid_s = req0_valid;
        end else begin
            sel_valid_s   = req0_valid;
            sel_we_s      = req0_we;
            sel_addr_s    = req0_addr;
            sel_wdata_s   = req0_wdata;
            sel_lock_s    = req0_lock;
            other_valid_s = req1_valid;
        end
    end

    // Access qualifiers; gating with rst keeps the reset cycle free of writes.
    always_comb begin
        access_s = (state_r == GRANT) && sel_valid_s && !rst;
        wr_s     = access_s && sel_we_s;
        rd0_s    = access_s && !sel_we_s && !gsel_r;
        rd1_s    = access_s && !sel_we_s && gsel_r;
    end

    // Memory port and handshake outputs; everything idles at zero.
    always_comb begin
        req0_ready = access_s && !gsel_r;
        req1_ready = access_s && gsel_r;
        mem_wen    = wr_s;
        if (access_s) begin
            mem_raddr = sel_addr_s;
            mem_waddr = sel_addr_s;
        end else begin
            mem_raddr = {ADDR_W{1'b0}};
            mem_waddr = {ADDR_W{1'b0}};
        end
        if (wr_s) begin
            mem_wdata = sel_wdata_s;
        end else begin
            mem_wdata = {DATA_W{1'b0}};
        end
    end

    // Next-state logic: grant selection, burst accounting, rr pointer update.
    always_comb begin
        state_s   = state_r;
        gsel_s    = gsel_r;
        rr_last_s = rr_last_r;
        cnt_s     = cnt_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_s = GRANT;
                    gsel_s  = pick_s;
                    cnt_s   = CNT_ONE;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT: begin
                if (!sel_valid_s) begin
                    state_s = IDLE;
                end else if (sel_lock_s && (cnt_r < CNT_MAX)) begin
                    cnt_s = cnt_r + CNT_ONE;
                end else if (sel_lock_s && !other_valid_s) begin
                    // Burst limit only matters when someone else is waiting.
                    cnt_s = CNT_ONE;
                end else begin
                    state_s   = IDLE;
                    rr_last_s = gsel_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            gsel_r    <= 1'b0;
            rr_last_r <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_s;
            gsel_r    <= gsel_s;
            rr_last_r <= rr_last_s;
            cnt_r     <= cnt_s;
        end
    end

    // Read return path: capture at the end of the read cycle, pulse rvalid next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_rvalid <= 1'b0;
            req1_rvalid <= 1'b0;
            req0_rdata  <= {DATA_W{1'b0}};
            req1_rdata  <= {DATA_W{1'b0}};
        end else begin
            req0_rvalid <= rd0_s;
            req1_rvalid <= rd1_s;
            if (rd0_s) begin
                req0_rdata <= mem_rdata;
            end else begin
                req0_rdata <= req0_rdata;
            end
            if (rd1_s) begin
                req1_rdata <= mem_rdata;
            end else begin
                req1_rdata <= req1_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Self-checking bench for mem_port_arb: directed scenarios plus randomized
// traffic, all compared against a transaction-level arbitration model.
module tb_mem_port_arb;

    localparam int MAXB = 4;
    localparam int NONE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tv[2];
    logic        twe[2];
    logic [15:0] taddr[2];
    logic [15:0] twd[2];
    logic        tlk[2];

    logic        req0_ready, req1_ready, req0_rvalid, req1_rvalid;
    logic [15:0] req0_rdata, req1_rdata;
    logic [15:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_wen;

    logic [15:0] tb_mem  [0:65535];
    logic [15:0] ref_mem [0:65535];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit          m_grant;
    int          m_g, m_last, m_run;
    bit          m_pend[2];
    logic [15:0] m_held[2];
    bit          hs[2];

    // observed DUT values at the last check point
    int          obs_id;
    logic        obs_r0, obs_wen;
    logic [15:0] obs_waddr, obs_wdata;

    mem_port_arb #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(tv[0]), .req0_we(twe[0]), .req0_addr(taddr[0]),
        .req0_wdata(twd[0]), .req0_lock(tlk[0]),
        .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(tv[1]), .req1_we(twe[1]), .req1_addr(taddr[1]),
        .req1_wdata(twd[1]), .req1_lock(tlk[1]),
        .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = tb_mem[mem_raddr];
    always @(posedge clk) if (mem_wen) tb_mem[mem_waddr] <= mem_wdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_grant = 1'b0; m_g = 0; m_last = 1; m_run = 0;
        m_pend  = '{1'b0, 1'b0};
        m_held  = '{16'h0000, 16'h0000};
    endtask

    task automatic set_req(input int n, input logic v, input logic we,
                           input logic [15:0] a, input logic [15:0] d, input logic lk);
        tv[n] = v; twe[n] = we; taddr[n] = a; twd[n] = d; tlk[n] = lk;
    endtask

    // Compare every output against what the model says this cycle must show.
    task automatic check_cycle();
        bit acc, wr;
        if (rst) model_reset();
        acc = m_grant && tv[m_g];
        wr  = acc && twe[m_g];
        obs_r0 = req0_ready; obs_wen = mem_wen;
        obs_waddr = mem_waddr; obs_wdata = mem_wdata;
        obs_id = req0_ready ? 0 : (req1_ready ? 1 : NONE);
        check_eq("ready0", {31'd0, req0_ready}, {31'd0, acc && m_g == 0});
        check_eq("ready1", {31'd0, req1_ready}, {31'd0, acc && m_g == 1});
        check_eq("mem_wen", {31'd0, mem_wen}, {31'd0, wr});
        check_eq("mem_raddr", {16'd0, mem_raddr}, {16'd0, acc ? taddr[m_g] : 16'h0000});
        check_eq("mem_waddr", {16'd0, mem_waddr}, {16'd0, acc ? taddr[m_g] : 16'h0000});
        check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, wr ? twd[m_g] : 16'h0000});
        check_eq("rvalid0", {31'd0, req0_rvalid}, {31'd0, m_pend[0]});
        check_eq("rvalid1", {31'd0, req1_rvalid}, {31'd0, m_pend[1]});
        check_eq("rdata0", {16'd0, req0_rdata}, {16'd0, m_held[0]});
        check_eq("rdata1", {16'd0, req1_rdata}, {16'd0, m_held[1]});
    endtask

    // Apply the arbitration rules for the cycle that ends at this rising edge.
    task automatic model_advance();
        int other;
        hs = '{1'b0, 1'b0};
        if (rst) begin
            model_reset();
        end else begin
            m_pend = '{1'b0, 1'b0};
            if (!m_grant) begin
                if (tv[0] || tv[1]) begin
                    if (tv[0] && tv[1]) m_g = 1 - m_last;
                    else m_g = tv[1] ? 1 : 0;
                    m_grant = 1'b1;
                    m_run = 1;
                end
            end else if (!tv[m_g]) begin
                m_grant = 1'b0;
            end else begin
                other = 1 - m_g;
                hs[m_g] = 1'b1;
                if (twe[m_g]) ref_mem[taddr[m_g]] = twd[m_g];
                else begin
                    m_pend[m_g] = 1'b1;
                    m_held[m_g] = ref_mem[taddr[m_g]];
                end
                if (tlk[m_g] && m_run < MAXB) m_run++;
                else if (tlk[m_g] && !tv[other]) m_run = 1;
                else begin
                    m_grant = 1'b0;
                    m_last = m_g;
                end
            end
        end
    endtask

    // One clock: check mid-cycle, update model at the edge, return just after it.
    task automatic tick();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic do_reset();
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seq[16];
        int run, cnt;
        logic [15:0] old;
        bit going;

        for (int i = 0; i < 65536; i++) begin
            tb_mem[i]  = 16'(i * 7 + 3);
            ref_mem[i] = 16'(i * 7 + 3);
        end
        model_reset();
        do_reset();

        // single write after reset
        set_req(0, 1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
        tick();
        check_eq("d34_ready_c1", {31'd0, obs_r0}, 32'd0);
        tick();
        check_eq("d34_ready_c2", {31'd0, obs_r0}, 32'd1);
        check_eq("d34_wen", {31'd0, obs_wen}, 32'd1);
        check_eq("d34_waddr", {16'd0, obs_waddr}, 32'h0010);
        check_eq("d34_wdata", {16'd0, obs_wdata}, 32'hBEEF);
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        check_eq("d34_wen_after", {31'd0, obs_wen}, 32'd0);
        check_eq("d34_mem", {16'd0, tb_mem[16'h0010]}, 32'hBEEF);

        // both valid, unlocked reads: alternation and 1-per-2-cycle rate
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0030, 16'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0);
        cnt = 0; run = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (obs_id != NONE) begin
                if (run < 4) seq[run] = obs_id;
                run++;
            end
            for (int n = 0; n < 2; n++) if (hs[n]) taddr[n] = taddr[n] + 16'h0001;
        end
        check_eq("d35_count", run, 32'd6);
        for (int k = 0; k < 4; k++) check_eq("d35_order", seq[k], k % 2);

        // locked req0 versus waiting req1
        do_reset();
        set_req(0, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b1);
        set_req(1, 1'b1, 1'b0, 16'h0200, 16'h0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            tick();
            seq[c] = obs_id;
            for (int n = 0; n < 2; n++) if (hs[n]) taddr[n] = taddr[n] + 16'h0001;
        end
        run = 0; going = 1'b1;
        for (int c = 1; c < 14; c++) begin
            if (going && seq[c] == 0) run++;
            else going = 1'b0;
        end
        check_eq("d36_burst", run, 32'd4);
        check_eq("d36_gap", seq[5], NONE);
        check_eq("d36_req1", seq[6], 32'd1);

        // locked req1 alone runs past the burst limit
        do_reset();
        set_req(1, 1'b1, 1'b1, 16'h0300, 16'h1111, 1'b1);
        run = 0; cnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (obs_id == 1) begin
                run++;
                if (run > cnt) cnt = run;
            end else run = 0;
            if (hs[1]) begin
                taddr[1] = taddr[1] + 16'h0001;
                twd[1] = twd[1] + 16'h0101;
            end
        end
        check_eq("d37_run_gt4", {31'd0, cnt > 4}, 32'd1);

        // req0 withdraws before its grant cycle
        do_reset();
        old = tb_mem[16'h0400];
        set_req(0, 1'b1, 1'b1, 16'h0400, 16'h1234, 1'b0);
        tick();
        tv[0] = 1'b0;
        tick();
        check_eq("d38_ready0", {31'd0, obs_r0}, 32'd0);
        check_eq("d38_wen", {31'd0, obs_wen}, 32'd0);
        set_req(1, 1'b1, 1'b0, 16'h0500, 16'h0, 1'b0);
        tick();
        tick();
        check_eq("d38_idle_then_req1", obs_id, 32'd1);
        check_eq("d38_mem", {16'd0, tb_mem[16'h0400]}, {16'd0, old});

        // reset during a grant write cycle
        do_reset();
        old = tb_mem[16'h0050];
        set_req(0, 1'b1, 1'b1, 16'h0050, 16'hAAAA, 1'b0);
        tick();
        check_eq("d39_wen_pre", {31'd0, mem_wen}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("d39_wen", {31'd0, mem_wen}, 32'd0);
        check_eq("d39_ready0", {31'd0, req0_ready}, 32'd0);
        check_eq("d39_waddr", {16'd0, mem_waddr}, 32'd0);
        check_eq("d39_wdata", {16'd0, mem_wdata}, 32'd0);
        tick();
        check_eq("d39_mem", {16'd0, tb_mem[16'h0050]}, {16'd0, old});
        rst = 1'b0;
        set_req(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!tv[n] || hs[n]) begin
                    tv[n]    = ($urandom_range(3, 0) != 0);
                    twe[n]   = 1'($urandom_range(1, 0));
                    taddr[n] = 16'($urandom_range(15, 0));
                    twd[n]   = 16'($urandom);
                    tlk[n]   = ($urandom_range(2, 0) == 0);
                end else if ($urandom_range(39, 0) == 0) begin
                    tv[n] = 1'b0;
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
